// File: rtl/reg_file.sv
// reg_file: architectural register file with rename busy/tag tracking for a ROB-based core.
// Reads are combinational with commit bypass; x0 is hardwired to zero.
module reg_file #(
    parameter int REG_NUM   = 32,
    parameter int ROB_POS_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,
    input  logic                 rollback,
    input  logic                 decode,
    input  logic [4:0]           decode_rd,
    input  logic [ROB_POS_W-1:0] decode_rob_pos,
    input  logic [4:0]           decode_rs1,
    input  logic [4:0]           decode_rs2,
    output logic [31:0]          rs1_val,
    output logic [31:0]          rs2_val,
    output logic                 rs1_busy,
    output logic                 rs2_busy,
    output logic [ROB_POS_W-1:0] rs1_rob_pos,
    output logic [ROB_POS_W-1:0] rs2_rob_pos,
    input  logic                 commit,
    input  logic [4:0]           commit_rd,
    input  logic [31:0]          commit_val,
    input  logic [ROB_POS_W-1:0] commit_rob_pos
);
    typedef struct packed {
        logic [31:0]          v;
        logic                 b;
        logic [ROB_POS_W-1:0] t;
    } rd_t;
    logic [31:0]          val  [REG_NUM];
    logic [ROB_POS_W-1:0] tag  [REG_NUM];
    logic [REG_NUM-1:0]   busy;
    rd_t                  rd1, rd2;
    // Commit writes the value, then a same-cycle decode overrides the busy/tag it would clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < REG_NUM; i++) begin
                val[i] <= '0;
                tag[i] <= '0;
            end
            busy <= '0;
        end else if (rdy) begin
            for (int i = 1; i < REG_NUM; i++) begin
                if (commit && commit_rd == 5'(i))
                    val[i] <= commit_val;
                if (rollback) begin
                    busy[i] <= 1'b0;
                    tag[i]  <= '0;
                end else if (decode && decode_rd == 5'(i)) begin
                    busy[i] <= 1'b1;
                    tag[i]  <= decode_rob_pos;
                end else if (commit && commit_rd == 5'(i) && tag[i] == commit_rob_pos) begin
                    busy[i] <= 1'b0;
                end
            end
        end
    end
    function automatic rd_t read_port(input logic [4:0] rs);
        rd_t  r;
        logic live, hit;
        live = !rst && rs != 5'd0 && int'(rs) < REG_NUM;
        hit  = live && busy[rs] && commit && commit_rd == rs && tag[rs] == commit_rob_pos;
        r.v  = !live ? '0 : hit ? commit_val : val[rs];
        r.b  = live && busy[rs] && !hit;
        r.t  = live ? tag[rs] : '0;
        return r;
    endfunction
    always_comb begin
        rd1 = read_port(decode_rs1);
        rd2 = read_port(decode_rs2);
    end
    assign rs1_val     = rd1.v;
    assign rs1_busy    = rd1.b;
    assign rs1_rob_pos = rd1.t;
    assign rs2_val     = rd2.v;
    assign rs2_busy    = rd2.b;
    assign rs2_rob_pos = rd2.t;
endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: scoreboard bench for reg_file with directed scenarios and randomized traffic.
module tb_reg_file;
    logic        clk = 1'b0;
    logic        rst, rdy, rollback, decode, commit;
    logic [4:0]  decode_rd, decode_rs1, decode_rs2, commit_rd;
    logic [3:0]  decode_rob_pos, commit_rob_pos;
    logic [31:0] commit_val;
    logic [31:0] rs1_val, rs2_val;
    logic        rs1_busy, rs2_busy;
    logic [3:0]  rs1_rob_pos, rs2_rob_pos;
    reg_file #(.REG_NUM(32), .ROB_POS_W(4)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
        .decode(decode), .decode_rd(decode_rd), .decode_rob_pos(decode_rob_pos),
        .decode_rs1(decode_rs1), .decode_rs2(decode_rs2),
        .rs1_val(rs1_val), .rs2_val(rs2_val), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .rs1_rob_pos(rs1_rob_pos), .rs2_rob_pos(rs2_rob_pos),
        .commit(commit), .commit_rd(commit_rd), .commit_val(commit_val),
        .commit_rob_pos(commit_rob_pos)
    );
    always #5 clk = ~clk;
    typedef struct {
        string       name;
        int          port;
        logic [31:0] v;
        logic        b;
        logic [3:0]  t;
        bit          ct;
    } exp_t;
    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_val  [32];
    bit          m_busy [32];
    logic [3:0]  m_tag  [32];
    function automatic exp_t model_read(string name, int port, logic [4:0] rs);
        exp_t e;
        e.name = name;
        e.port = port;
        if (rst || rs == 0) begin
            e.v = 0; e.b = 0; e.t = 0; e.ct = 1;
        end else if (commit && commit_rd == rs && m_busy[rs] && m_tag[rs] == commit_rob_pos) begin
            e.v = commit_val; e.b = 0; e.t = 0; e.ct = 0;
        end else begin
            e.v = m_val[rs]; e.b = m_busy[rs]; e.t = m_tag[rs]; e.ct = m_busy[rs];
        end
        return e;
    endfunction
    task automatic model_clear();
        for (int i = 0; i < 32; i++) begin
            m_val[i] = 0; m_busy[i] = 0; m_tag[i] = 0;
        end
    endtask
    task automatic model_update();
        bit clr;
        clr = commit && commit_rd != 0 && m_tag[commit_rd] == commit_rob_pos;
        if (commit && commit_rd != 0) m_val[commit_rd] = commit_val;
        if (rollback) begin
            for (int i = 0; i < 32; i++) begin
                m_busy[i] = 0; m_tag[i] = 0;
            end
        end else begin
            if (clr) m_busy[commit_rd] = 0;
            if (decode && decode_rd != 0) begin
                m_busy[decode_rd] = 1; m_tag[decode_rd] = decode_rob_pos;
            end
        end
    endtask
    task automatic want(string name, int port, logic [31:0] v, logic b, logic [3:0] t, bit ct);
        exp_t e;
        e.name = name; e.port = port; e.v = v; e.b = b; e.t = t; e.ct = ct;
        q.push_back(e);
    endtask
    // Expectations are queued before the cycle's negedge; state advances at the posedge.
    task automatic tick(string name);
        if (rst) model_clear();
        q.push_back(model_read({name, "/m1"}, 0, decode_rs1));
        q.push_back(model_read({name, "/m2"}, 1, decode_rs2));
        @(negedge clk);
        @(posedge clk);
        if (!rst && rdy) model_update();
        #1;
    endtask
    task automatic idle();
        rst = 0; rdy = 1; rollback = 0; decode = 0; commit = 0;
        decode_rd = 0; decode_rob_pos = 0; decode_rs1 = 0; decode_rs2 = 0;
        commit_rd = 0; commit_rob_pos = 0; commit_val = 0;
    endtask
    always @(negedge clk) begin
        while (q.size() > 0) begin
            automatic exp_t e = q.pop_front();
            automatic logic [31:0] v = e.port == 0 ? rs1_val : rs2_val;
            automatic logic        b = e.port == 0 ? rs1_busy : rs2_busy;
            automatic logic [3:0]  t = e.port == 0 ? rs1_rob_pos : rs2_rob_pos;
            checks++;
            if (v !== e.v || b !== e.b || (e.ct && t !== e.t)) begin
                errors++;
                $display("FAIL %s: got val=%h busy=%b tag=%0d, want val=%h busy=%b tag=%0d",
                         e.name, v, b, t, e.v, e.b, e.t);
            end
        end
    end
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end
    initial begin
        model_clear();
        idle();
        rst = 1; decode_rs1 = 5; decode_rs2 = 31;
        want("reset_rs1", 0, 0, 0, 0, 1);
        want("reset_rs2", 1, 0, 0, 0, 1);
        tick("reset");
        idle();
        decode = 1; decode_rd = 5; decode_rob_pos = 3;
        tick("dec5");
        idle(); decode_rs1 = 5;
        want("busy5", 0, 0, 1, 3, 1);
        tick("busy5");
        idle(); decode_rs1 = 5; commit = 1; commit_rd = 5; commit_rob_pos = 3; commit_val = 32'h1234;
        want("bypass5", 0, 32'h1234, 0, 0, 0);
        tick("bypass5");
        idle(); decode_rs1 = 5;
        want("after5", 0, 32'h1234, 0, 0, 0);
        tick("after5");
        idle(); decode = 1; decode_rd = 7; decode_rob_pos = 2;
        tick("dec7a");
        idle(); decode = 1; decode_rd = 7; decode_rob_pos = 9;
        tick("dec7b");
        idle(); decode_rs1 = 7; commit = 1; commit_rd = 7; commit_rob_pos = 2; commit_val = 32'hAA;
        want("stale7_same", 0, 0, 1, 9, 1);
        tick("stale7");
        idle(); decode_rs1 = 7;
        want("stale7_after", 0, 32'hAA, 1, 9, 1);
        tick("stale7_after");
        idle(); commit = 1; commit_rd = 4; commit_val = 32'h77;
        tick("w4");
        idle(); decode = 1; decode_rd = 4; decode_rob_pos = 6; decode_rs1 = 4;
        want("prerename4", 0, 32'h77, 0, 0, 0);
        tick("prerename4");
        idle(); decode_rs1 = 4;
        want("renamed4", 0, 32'h77, 1, 6, 1);
        tick("renamed4");
        idle(); decode = 1; decode_rd = 0; decode_rob_pos = 5;
        commit = 1; commit_rd = 0; commit_val = 32'hFFFF; decode_rs1 = 0;
        want("x0_same", 0, 0, 0, 0, 1);
        tick("x0");
        idle();
        want("x0_after", 0, 0, 0, 0, 1);
        tick("x0_after");
        idle(); decode = 1; decode_rd = 8; decode_rob_pos = 0;
        tick("dec8");
        idle(); decode_rs1 = 8; commit = 1; commit_rd = 8; commit_rob_pos = 0; commit_val = 32'h99;
        want("tag0_bypass", 0, 32'h99, 0, 0, 0);
        tick("tag0");
        idle(); decode = 1; decode_rd = 1; decode_rob_pos = 1;
        tick("dec1");
        idle(); decode = 1; decode_rd = 2; decode_rob_pos = 2;
        tick("dec2");
        idle(); rollback = 1; commit = 1; commit_rd = 1; commit_rob_pos = 4; commit_val = 32'h55;
        decode = 1; decode_rd = 3; decode_rob_pos = 5;
        tick("rollback");
        idle(); decode_rs1 = 1; decode_rs2 = 2;
        want("rb_x1", 0, 32'h55, 0, 0, 0);
        want("rb_x2", 1, 0, 0, 0, 0);
        tick("rb_a");
        idle(); decode_rs1 = 3; decode_rs2 = 7;
        want("rb_x3", 0, 0, 0, 0, 0);
        want("rb_x7", 1, 32'hAA, 0, 0, 0);
        tick("rb_b");
        idle(); decode = 1; decode_rd = 7; decode_rob_pos = 9;
        tick("dec7c");
        idle(); rst = 1; commit = 1; commit_rd = 7; commit_rob_pos = 9; commit_val = 32'h5;
        decode_rs1 = 7; decode_rs2 = 5;
        want("rst_rs1", 0, 0, 0, 0, 1);
        want("rst_rs2", 1, 0, 0, 0, 1);
        tick("rst_mid");
        idle(); decode_rs1 = 7; decode_rs2 = 5;
        want("postrst_rs1", 0, 0, 0, 0, 1);
        want("postrst_rs2", 1, 0, 0, 0, 1);
        tick("postrst");
        idle(); commit = 1; commit_rd = 10; commit_val = 32'h42;
        tick("w10");
        for (int k = 0; k < 2; k++) begin
            idle(); rdy = 0; decode = 1; decode_rd = 10; decode_rob_pos = 7; decode_rs1 = 10;
            want("hold10", 0, 32'h42, 0, 0, 0);
            tick("hold");
        end
        idle(); decode_rs1 = 10;
        want("held10", 0, 32'h42, 0, 0, 0);
        tick("held10");
        for (int n = 0; n < 1500; n++) begin
            rst            = ($urandom % 200) == 0;
            rdy            = ($urandom % 10) != 0;
            rollback       = ($urandom % 30) == 0;
            decode         = $urandom % 2;
            decode_rd      = 5'($urandom % 12);
            decode_rob_pos = 4'($urandom);
            commit         = $urandom % 2;
            commit_rd      = 5'($urandom % 12);
            commit_rob_pos = ($urandom % 2) ? m_tag[commit_rd] : 4'($urandom);
            commit_val     = $urandom;
            decode_rs1     = ($urandom % 3) == 0 ? commit_rd : 5'($urandom % 12);
            decode_rs2     = ($urandom % 3) == 0 ? decode_rd : 5'($urandom % 32);
            tick("rand");
        end
        idle();
        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending, want 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 SHALL use parameter REG_NUM, default 32, meaning architectural register count.
REQ-002 SHALL use parameter ROB_POS_W, default 4, meaning ROB tag width (16 entries).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-004 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-005 SHALL have port rdy  input  1  global enable; low = hold all state.
REQ-006 SHALL have port rollback  input  1  flush all rename state.
REQ-007 SHALL have port decode  input  1  issue of an instruction writing decode_rd.
REQ-008 SHALL have port decode_rd  input  5  destination register of issued instruction.
REQ-009 SHALL have port decode_rob_pos  input  ROB_POS_W  ROB tag allocated to the issued instruction.
REQ-010 SHALL have ports decode_rs1 / decode_rs2  input  5  source register indices.
REQ-011 SHALL have ports rs1_val / rs2_val  output  32  source value.
REQ-012 SHALL have ports rs1_busy / rs2_busy  output  1  source awaits in-flight producer.
REQ-013 SHALL have ports rs1_rob_pos / rs2_rob_pos  output  ROB_POS_W  producer tag, valid when busy.
REQ-014 SHALL have port commit  input  1  ROB retires a register write.
REQ-015 SHALL have port commit_rd  input  5  retired destination.
REQ-016 SHALL have port commit_val  input  32  retired value.
REQ-017 SHALL have port commit_rob_pos  input  ROB_POS_W  tag of retired entry.

Function
REQ-018 SHALL hold per register: val[31:0], busy, tag[ROB_POS_W-1:0].
REQ-019 SHALL treat x0 as constant: reads return val 0, busy 0, tag 0; decode/commit to x0 ignored.
REQ-020 SHALL produce read outputs combinationally from current state (zero latency).
REQ-021 SHALL bypass: if commit && commit_rd==rsN && rsN busy && tag==commit_rob_pos, outputs commit_val, busy 0.
REQ-022 SHALL NOT let same-cycle decode_rd affect rs1/rs2 outputs (sources read pre-rename).
REQ-023 SHALL, on decode (rdy, !rollback, rd!=0), set busy[rd]=1, tag[rd]=decode_rob_pos next edge.
REQ-024 SHALL, on commit (rdy, rd!=0), write val[commit_rd]=commit_val regardless of tag.
REQ-025 SHALL clear busy[commit_rd] on commit only when tag matches commit_rob_pos.
REQ-026 SHALL, when decode and commit target same rd in one cycle, write value and keep busy=1 with new decode tag.
REQ-027 SHALL, on rollback (rdy high), clear all busy and tag; same-cycle commit value still written; same-cycle decode dropped.
REQ-028 SHALL, when rdy low, hold all state; read outputs remain combinationally valid.
REQ-029 SHALL compare tags at full ROB_POS_W width; tag 0 is an ordinary valid tag.

Reset
REQ-030 SHALL on rst (asynchronous, any cycle) clear all val, busy, tag to 0 immediately.
REQ-031 SHALL drive rs1/rs2 outputs to 0 while rst high; rst dominates rollback, decode, commit.

Verification
REQ-032 SHALL verify: decode rd=5 tag=3, next cycle read rs1=5 -> busy 1, rob_pos 3; commit rd=5 tag=3 val=0x1234 -> same-cycle read val 0x1234 busy 0; next cycle busy 0.
REQ-033 SHALL verify: decode rd=7 tag=2, then decode rd=7 tag=9, then commit rd=7 tag=2 val=0xAA -> val 0xAA, busy 1, tag 9.
REQ-034 SHALL verify: decode rd=4 tag=6 and read rs1=4 same cycle -> old value, busy 0; next cycle busy 1 tag 6.
REQ-035 SHALL verify: decode rd=0, commit rd=0 val=0xFFFF -> rs1=0 reads val 0 busy 0.
REQ-036 SHALL verify: busy on x1,x2; rollback with commit rd=1 val=0x55 and decode rd=3 -> all busy 0, x1=0x55, x3 not busy.
REQ-037 SHALL verify: assert rst mid-sequence between edges -> outputs 0 before next posedge; rdy low two cycles with decode high -> no state change.
